// File: rtl/seq_datapath.sv
// Multi-cycle lab processor: run-time loadable program RAM, FETCH/EXEC sequencer,
// 32-entry register file with hardwired r0, and a small ALU.
module seq_datapath #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned PROG_DEPTH = 8,
   parameter int unsigned PC_W       = $clog2(PROG_DEPTH),
   parameter bit          WRAP       = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [PC_W-1:0]   prog_addr,
   input  logic [31:0]       prog_data,
   input  logic              start,
   input  logic              step_mode,
   input  logic              step,
   output logic              busy,
   output logic              done,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic [4:0]        wb_addr
);

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned REG_N   = 32;
   localparam int unsigned RADDR_W = 5;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_HALT = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SHR  = 3'b101;
   localparam logic [2:0] OP_ADDI = 3'b110;
   localparam logic [2:0] OP_SUBI = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                result_valid_q, result_valid_d;
   logic [RADDR_W-1:0]  wb_addr_q, wb_addr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [INSTR_W-1:0]  ram_q [PROG_DEPTH];
   logic [DATA_W-1:0]   rf_q  [REG_N];

   logic [2:0]          op;
   logic [RADDR_W-1:0]  rd, rs1, rs2;
   logic [DATA_W-1:0]   opa, opb, imm, alu;
   logic                writes, rf_we, ram_we;

   // Instruction decode and operand fetch; r0 always reads as zero
   assign op     = ir_q[31:29];
   assign rd     = ir_q[28:24];
   assign rs1    = ir_q[23:19];
   assign rs2    = ir_q[18:14];
   assign imm    = DATA_W'(ir_q[18:0]);
   assign opa    = (rs1 == '0) ? '0 : rf_q[rs1];
   assign opb    = (rs2 == '0) ? '0 : rf_q[rs2];
   assign writes = op[2] | op[1];
   assign rf_we  = (state_q == S_EXEC) && writes && (rd != '0);
   assign ram_we = prog_we && ((state_q == S_IDLE) || (state_q == S_DONE));

   // ALU; shift amounts of DATA_W or more shift everything out
   always_comb begin
      alu = '0;
      case (op)
         OP_NOP:  alu = '0;
         OP_HALT: alu = '0;
         OP_ADD:  alu = opa + opb;
         OP_SUB:  alu = opa - opb;
         OP_SHL:  alu = opa << opb;
         OP_SHR:  alu = opa >> opb;
         OP_ADDI: alu = opa + imm;
         OP_SUBI: alu = opa - imm;
      endcase
   end

   // Sequencer next-state and registered-output logic
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      ir_d           = ir_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      wb_addr_d      = wb_addr_q;
      busy_d         = 1'b0;
      done_d         = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = '0;
            end
         end
         S_FETCH: begin
            ir_d    = ram_q[pc_q];
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (writes) begin
               result_d       = alu;
               wb_addr_d      = rd;
               result_valid_d = 1'b1;
            end
            if (op == OP_HALT) begin
               state_d = S_DONE;
            end else if (!WRAP && (pc_q == PC_W'(PROG_DEPTH - 1))) begin
               state_d = S_DONE;
            end else begin
               pc_d    = pc_q + PC_W'(1);
               state_d = step_mode ? S_PAUSE : S_FETCH;
            end
         end
         S_PAUSE: begin
            if (step) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_PAUSE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         pc_q           <= '0;
         ir_q           <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         wb_addr_q      <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         for (int i = 0; i < REG_N; i++) rf_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         ir_q           <= ir_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         wb_addr_q      <= wb_addr_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         if (rf_we) rf_q[rd] <= alu;
      end
   end

   // Program RAM survives reset so a reloaded run can follow an abort
   always_ff @(posedge clk) begin
      if (ram_we) ram_q[prog_addr] <= prog_data;
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign pc           = pc_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign wb_addr      = wb_addr_q;

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed timing/boundary programs plus random programs
// scored against an instruction-level architectural model.
`timescale 1ns/1ps
module tb_seq_datapath;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned PW    = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, prog_we, start, step_mode, step;
   logic [PW-1:0] prog_addr;
   logic [31:0]   prog_data;
   logic          busy, done, result_valid;
   logic [PW-1:0] pc;
   logic [DW-1:0] result;
   logic [4:0]    wb_addr;

   logic          w_reset, w_prog_we, w_start, w_step_mode, w_step;
   logic [PW-1:0] w_prog_addr;
   logic [31:0]   w_prog_data;
   logic          w_busy, w_done, w_result_valid;
   logic [PW-1:0] w_pc;
   logic [7:0]    w_result;
   logic [4:0]    w_wb_addr;

   seq_datapath #(.DATA_W(DW), .PROG_DEPTH(DEPTH), .PC_W(PW), .WRAP(1'b0)) u_dut (
      .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .start(start), .step_mode(step_mode), .step(step),
      .busy(busy), .done(done), .pc(pc), .result(result),
      .result_valid(result_valid), .wb_addr(wb_addr)
   );

   seq_datapath #(.DATA_W(8), .PROG_DEPTH(DEPTH), .PC_W(PW), .WRAP(1'b1)) u_wrap (
      .clk(clk), .reset(w_reset), .prog_we(w_prog_we), .prog_addr(w_prog_addr),
      .prog_data(w_prog_data), .start(w_start), .step_mode(w_step_mode), .step(w_step),
      .busy(w_busy), .done(w_done), .pc(w_pc), .result(w_result),
      .result_valid(w_result_valid), .wb_addr(w_wb_addr)
   );

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wb_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] prog  [DEPTH];
   logic [31:0] mregs [32];
   wb_t         exp_q [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic logic [31:0] ri(input logic [2:0] op, input int rd, input int rs1, input int rs2);
      return {op, 5'(rd), 5'(rs1), 5'(rs2), 14'd0};
   endfunction

   function automatic logic [31:0] ii(input logic [2:0] op, input int rd, input int rs1, input int imm);
      return {op, 5'(rd), 5'(rs1), 19'(imm)};
   endfunction

   // Architectural ALU: arithmetic modulo 2^w, over-wide shifts give zero
   function automatic logic [31:0] alu_m(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] imm, input int w);
      logic [63:0] mask, r;
      mask = (64'd1 << w) - 64'd1;
      case (op)
         3'b010:  r = 64'(a) + 64'(b);
         3'b011:  r = 64'(a) - 64'(b);
         3'b100:  r = (b >= 32'(w)) ? 64'd0 : (64'(a) << b);
         3'b101:  r = (b >= 32'(w)) ? 64'd0 : (64'(a) >> b);
         3'b110:  r = 64'(a) + 64'(imm);
         3'b111:  r = 64'(a) - 64'(imm);
         default: r = 64'd0;
      endcase
      return 32'(r & mask);
   endfunction

   // Executes prog[] on the model registers, queueing the expected write-backs
   task automatic model_run(output int fpc);
      int          p;
      logic [31:0] ins, res;
      logic [2:0]  op;
      logic [4:0]  rd, rs1, rs2;
      p = 0;
      exp_q.delete();
      while (1) begin
         ins = prog[p];
         op  = ins[31:29];
         rd  = ins[28:24];
         rs1 = ins[23:19];
         rs2 = ins[18:14];
         if (op == 3'b001) break;
         if (op >= 3'b010) begin
            res = alu_m(op, mregs[rs1], mregs[rs2], 32'(ins[18:0]), 32);
            if (rd != 5'd0) mregs[rd] = res;
            exp_q.push_back('{a: rd, d: res});
         end
         if (p == DEPTH - 1) break;
         p++;
      end
      fpc = p;
   endtask

   task automatic load_prog(input int first);
      for (int i = first; i < DEPTH; i++) begin
         prog_we   = 1'b1;
         prog_addr = PW'(i);
         prog_data = prog[i];
         cyc();
      end
      prog_we = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
   endtask

   // Starts a run and scores every write-back against exp_q until DONE
   task automatic run_check(input string tag, input int fpc, input bit stepping,
                            input bit poke, input bit w0_with_start);
      wb_t           e;
      logic [PW-1:0] held_pc;
      bit            fin;
      fin = 1'b0;
      if (w0_with_start) begin
         prog_we   = 1'b1;
         prog_addr = '0;
         prog_data = prog[0];
      end
      start = 1'b1;
      cyc();
      start   = 1'b0;
      prog_we = 1'b0;
      for (int n = 1; n <= 200 && !fin; n++) begin
         if (poke && n == 4) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = ii(3'b001, 0, 0, 0);
            start     = 1'b1;
         end else if (poke && n == 5) begin
            prog_we = 1'b0;
            start   = 1'b0;
         end
         if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk({tag, " unexpected_wb"}, 64'(result_valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk({tag, " wb_addr"}, 64'(wb_addr), 64'(e.a));
               chk({tag, " result"}, 64'(result), 64'(e.d));
            end
            if (stepping) begin
               held_pc = pc;
               for (int k = 0; k < 4; k++) begin
                  cyc();
                  chk({tag, " pause_rv"}, 64'(result_valid), 64'd0);
                  chk({tag, " pause_busy"}, 64'(busy), 64'd1);
                  chk({tag, " pause_pc"}, 64'(pc), 64'(held_pc));
               end
               step = 1'b1;
               cyc();
               step = 1'b0;
               continue;
            end
         end
         if (done === 1'b1) fin = 1'b1;
         else cyc();
      end
      chk({tag, " done"}, 64'(done), 64'd1);
      chk({tag, " pending_wb"}, 64'(exp_q.size()), 64'd0);
      chk({tag, " final_pc"}, 64'(pc), 64'(fpc));
      chk({tag, " idle_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic set_demo_prog();
      prog[0] = ii(3'b110, 10, 0, 10);
      prog[1] = ii(3'b110, 15, 0, 15);
      prog[2] = ri(3'b010, 25, 10, 15);
      prog[3] = ii(3'b111, 20, 25, 5);
      prog[4] = ii(3'b110, 5, 0, 2);
      prog[5] = ri(3'b100, 30, 25, 5);
      prog[6] = ii(3'b001, 0, 0, 0);
      prog[7] = 32'd0;
   endtask

   initial begin
      int            fpc;
      int            dir_res  [6] = '{10, 15, 25, 20, 2, 100};
      int            dir_addr [6] = '{10, 15, 25, 20, 5, 30};
      logic [PW-1:0] held_pc;
      bit            rv_exp;

      reset = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      start = 1'b0; step_mode = 1'b0; step = 1'b0;
      w_reset = 1'b1; w_prog_we = 1'b0; w_prog_addr = '0; w_prog_data = '0;
      w_start = 1'b0; w_step_mode = 1'b0; w_step = 1'b0;
      cyc();
      do_reset();
      w_reset = 1'b0;

      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset pc", 64'(pc), 64'd0);
      chk("reset result", 64'(result), 64'd0);
      chk("reset result_valid", 64'(result_valid), 64'd0);
      chk("reset wb_addr", 64'(wb_addr), 64'd0);

      // Demo program with cycle-exact write-back timing
      set_demo_prog();
      model_run(fpc);
      load_prog(0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         rv_exp = (c >= 3) && (c <= 13) && (c % 2 == 1);
         chk($sformatf("demo rv c%0d", c), 64'(result_valid), 64'(rv_exp));
         chk($sformatf("demo busy c%0d", c), 64'(busy), 64'd1);
         if (rv_exp) begin
            chk($sformatf("demo result c%0d", c), 64'(result), 64'(dir_res[(c - 3) / 2]));
            chk($sformatf("demo wb_addr c%0d", c), 64'(wb_addr), 64'(dir_addr[(c - 3) / 2]));
         end
         cyc();
      end
      for (int c = 0; c < 8 && done !== 1'b1; c++) cyc();
      chk("demo done", 64'(done), 64'd1);
      chk("demo pc", 64'(pc), 64'd6);
      chk("demo busy_end", 64'(busy), 64'd0);

      // Single-step from DONE, registers retained
      step_mode = 1'b1;
      model_run(fpc);
      run_check("step", fpc, 1'b1, 1'b0, 1'b0);
      step_mode = 1'b0;
      held_pc = pc;
      step = 1'b1;
      cyc();
      step = 1'b0;
      cyc();
      chk("step_in_done done", 64'(done), 64'd1);
      chk("step_in_done pc", 64'(pc), 64'(held_pc));

      // Writes and start while busy are ignored
      model_run(fpc);
      run_check("busy_poke", fpc, 1'b0, 1'b1, 1'b0);
      model_run(fpc);
      run_check("rerun", fpc, 1'b0, 1'b0, 1'b0);

      // Reset during EXEC aborts the write-back
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      chk("abort rv", 64'(result_valid), 64'd0);
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort pc", 64'(pc), 64'd0);
      chk("abort wb_addr", 64'(wb_addr), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      cyc();
      model_run(fpc);
      run_check("after_abort", fpc, 1'b0, 1'b0, 1'b0);

      // r0 hardwired zero; word 0 written in the same cycle as start
      for (int i = 0; i < DEPTH; i++) prog[i] = 32'd0;
      prog[0] = ii(3'b110, 0, 0, 5);
      prog[1] = ri(3'b010, 2, 0, 0);
      prog[2] = ii(3'b001, 0, 0, 0);
      model_run(fpc);
      exp_q.delete();
      exp_q.push_back('{a: 5'd0, d: 32'd5});
      exp_q.push_back('{a: 5'd2, d: 32'd0});
      load_prog(1);
      run_check("r0", fpc, 1'b0, 1'b0, 1'b1);

      // Over-wide shift and underflow
      for (int i = 0; i < DEPTH; i++) prog[i] = 32'd0;
      prog[0] = ii(3'b110, 1, 0, 1);
      prog[1] = ii(3'b110, 2, 0, 32);
      prog[2] = ri(3'b100, 3, 1, 2);
      prog[3] = ri(3'b011, 4, 0, 1);
      prog[4] = ii(3'b001, 0, 0, 0);
      model_run(fpc);
      exp_q.delete();
      exp_q.push_back('{a: 5'd1, d: 32'd1});
      exp_q.push_back('{a: 5'd2, d: 32'd32});
      exp_q.push_back('{a: 5'd3, d: 32'd0});
      exp_q.push_back('{a: 5'd4, d: 32'hFFFF_FFFF});
      load_prog(0);
      run_check("edge_ops", fpc, 1'b0, 1'b0, 1'b0);

      // Random programs against the model (one after a reset)
      for (int t = 0; t < 14; t++) begin
         for (int i = 0; i < DEPTH; i++) begin
            prog[i] = $urandom;
            if ($urandom_range(0, 3) == 0) prog[i][18:14] = 5'($urandom_range(0, 40));
         end
         if (t == 7) do_reset();
         model_run(fpc);
         load_prog(0);
         run_check($sformatf("rand%0d", t), fpc, 1'b0, 1'b0, 1'b0);
      end

      // 8-bit wrapping instance: word0 truncates 300, word7 counts r1 per lap
      for (int i = 0; i < DEPTH; i++) begin
         w_prog_we   = 1'b1;
         w_prog_addr = PW'(i);
         w_prog_data = (i == 0) ? ii(3'b110, 3, 0, 300) :
                       (i == 7) ? ii(3'b110, 1, 1, 1) : 32'd0;
         cyc();
      end
      w_prog_we = 1'b0;
      w_start = 1'b1;
      cyc();
      w_start = 1'b0;
      for (int c = 1; c <= 50; c++) begin
         rv_exp = (c % 16 == 3) || ((c % 16 == 1) && (c > 1));
         chk($sformatf("wrap rv c%0d", c), 64'(w_result_valid), 64'(rv_exp));
         chk($sformatf("wrap pc c%0d", c), 64'(w_pc), 64'(((c - 1) / 2) % 8));
         chk($sformatf("wrap busy c%0d", c), 64'(w_busy), 64'd1);
         chk($sformatf("wrap done c%0d", c), 64'(w_done), 64'd0);
         if (rv_exp && (c % 16 == 3)) begin
            chk($sformatf("wrap trunc c%0d", c), 64'(w_result), 64'd44);
            chk($sformatf("wrap trunc_addr c%0d", c), 64'(w_wb_addr), 64'd3);
         end else if (rv_exp) begin
            chk($sformatf("wrap count c%0d", c), 64'(w_result), 64'(c / 16));
            chk($sformatf("wrap count_addr c%0d", c), 64'(w_wb_addr), 64'd1);
         end
         cyc();
      end
      w_reset = 1'b1;
      cyc();
      w_reset = 1'b0;
      chk("wrap stop busy", 64'(w_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
